reg_file_dual: RTL

- Dual-issue integer register file with a pending-write scoreboard.
- Sits between the dual-lane write-back stage (producer of the lane data/address pairs) and the decode/issue stage (consumer).
- Accepts two writes per cycle and serves four combinational read ports (rs/rt per lane).
- Tracks which registers have in-flight producers, so decode can stall on RAW hazards.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/reg_file_dual_if.sv | 33 +++
 rtl/reg_file_dual_scoreboard.sv | 37 +++
 rtl/reg_file_dual.sv | 71 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, the hardwired-zero register index and the read-port record
// for the dual-issue register file.
package regfile_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int NUM_REGS  = 32;
  localparam int NUM_LANES = 2;
  localparam int NUM_RD    = 4;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
    logic  busy;
  } rd_port_t;
endpackage

// File: rtl/reg_file_dual_if.sv
// Write-back, issue and read-port bundle between the dual-lane pipeline
// (master) and the register file (slave).
interface reg_file_dual_if;
  import regfile_pkg::*;

  logic  wr_en_1, wr_en_2;
  addr_t WR_addr_1, WR_addr_2;
  data_t WB_data_1, WB_data_2;

  addr_t rs_addr_1, rt_addr_1, rs_addr_2, rt_addr_2;
  data_t rs_data_1, rt_data_1, rs_data_2, rt_data_2;
  logic  rs_busy_1, rt_busy_1, rs_busy_2, rt_busy_2;

  logic  issue_en_1, issue_en_2;
  addr_t issue_rd_1, issue_rd_2;
  logic  stall;

  modport master (
    output wr_en_1, WR_addr_1, WB_data_1, wr_en_2, WR_addr_2, WB_data_2,
    output rs_addr_1, rt_addr_1, rs_addr_2, rt_addr_2,
    output issue_en_1, issue_rd_1, issue_en_2, issue_rd_2,
    input  rs_data_1, rt_data_1, rs_data_2, rt_data_2,
    input  rs_busy_1, rt_busy_1, rs_busy_2, rt_busy_2, stall
  );

  modport slave (
    input  wr_en_1, WR_addr_1, WB_data_1, wr_en_2, WR_addr_2, WB_data_2,
    input  rs_addr_1, rt_addr_1, rs_addr_2, rt_addr_2,
    input  issue_en_1, issue_rd_1, issue_en_2, issue_rd_2,
    output rs_data_1, rt_data_1, rs_data_2, rt_data_2,
    output rs_busy_1, rt_busy_1, rs_busy_2, rt_busy_2, stall
  );
endinterface

// File: rtl/reg_file_dual_scoreboard.sv
// Pending-write scoreboard: one busy flop per nonzero register, set on issue,
// cleared on write-back, with issue taking priority on the same edge.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_LANES-1:0]  set_en,
  input  addr_t [NUM_LANES-1:0] set_rd,
  input  logic [NUM_LANES-1:0]  clr_en,
  input  addr_t [NUM_LANES-1:0] clr_rd,
  input  addr_t [NUM_RD-1:0]    rd_addr,
  output logic [NUM_RD-1:0]     rd_busy
);
  logic [NUM_REGS-1:1] busy_q, set_hit, clr_hit;
  logic [NUM_REGS-1:0] busy_all;

  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    for (int r = 1; r < NUM_REGS; r++)
      for (int l = 0; l < NUM_LANES; l++) begin
        if (set_en[l] && set_rd[l] == ADDR_W'(r)) set_hit[r] = 1'b1;
        if (clr_en[l] && clr_rd[l] == ADDR_W'(r)) clr_hit[r] = 1'b1;
      end
  end

  // A same-edge issue is a younger producer than the retiring write.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_q <= '0;
    else        busy_q <= (busy_q & ~clr_hit) | set_hit;

  assign busy_all = {busy_q, 1'b0};

  always_comb
    for (int p = 0; p < NUM_RD; p++) rd_busy[p] = busy_all[rd_addr[p]];
endmodule

// File: rtl/reg_file_dual.sv
// Dual-issue register file: two writes per edge (lane 2 wins collisions),
// four combinational read ports, RAW scoreboard and stall.
// Optional same-cycle write-to-read forwarding under `REGFILE_BYPASS_EN.
module reg_file_dual
  import regfile_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  reg_file_dual_if.slave bus
);
  logic  [NUM_LANES-1:0] wr_en, iss_en;
  addr_t [NUM_LANES-1:0] wr_addr, iss_rd;
  data_t [NUM_LANES-1:0] wr_data;
  addr_t [NUM_RD-1:0]    rd_addr;
  logic  [NUM_RD-1:0]    sb_busy, busy;
  data_t                 regs_q [NUM_REGS-1:1];
  rd_port_t              rp [NUM_RD];

  assign wr_en   = {bus.wr_en_2,   bus.wr_en_1};
  assign wr_addr = {bus.WR_addr_2, bus.WR_addr_1};
  assign wr_data = {bus.WB_data_2, bus.WB_data_1};
  assign iss_en  = {bus.issue_en_2, bus.issue_en_1};
  assign iss_rd  = {bus.issue_rd_2, bus.issue_rd_1};
  assign rd_addr = {bus.rt_addr_2, bus.rs_addr_2, bus.rt_addr_1, bus.rs_addr_1};

  // Lanes applied in order, so lane 2's NBA lands last on a collision.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 1; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++)
        if (wr_en[l] && wr_addr[l] != ZERO_REG) regs_q[wr_addr[l]] <= wr_data[l];
    end

  reg_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (iss_en),
    .set_rd  (iss_rd),
    .clr_en  (wr_en),
    .clr_rd  (wr_addr),
    .rd_addr (rd_addr),
    .rd_busy (sb_busy)
  );

  always_comb
    for (int p = 0; p < NUM_RD; p++) begin
      rp[p].addr = rd_addr[p];
      rp[p].data = (rp[p].addr == ZERO_REG) ? '0 : regs_q[rp[p].addr];
      rp[p].busy = sb_busy[p];
`ifdef REGFILE_BYPASS_EN
      // The forwarded write also retires the producer, so the hazard is gone.
      for (int l = 0; l < NUM_LANES; l++)
        if (rst_n && wr_en[l] && wr_addr[l] != ZERO_REG && wr_addr[l] == rp[p].addr) begin
          rp[p].data = wr_data[l];
          rp[p].busy = 1'b0;
        end
`endif
      busy[p] = rp[p].busy;
    end

  assign bus.rs_data_1 = rp[0].data;
  assign bus.rt_data_1 = rp[1].data;
  assign bus.rs_data_2 = rp[2].data;
  assign bus.rt_data_2 = rp[3].data;
  assign bus.rs_busy_1 = busy[0];
  assign bus.rt_busy_1 = busy[1];
  assign bus.rs_busy_2 = busy[2];
  assign bus.rt_busy_2 = busy[3];
  assign bus.stall     = |busy;
endmodule
